// File: rtl/ring_flit_pkg.sv
// Shared flit format for the ring switch and its local network interface.
// Flit layout (MSB..LSB): payload[2:0], valid, destination[3:0].
package ring_flit_pkg;

  localparam int FLIT_W = 8;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 3;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              valid;
    logic [ADDR_W-1:0] dest;
  } flit_t;

  // A switch output carries an ejection for this node only when valid and addressed to it.
  function automatic logic is_eject(input flit_t f, input logic [ADDR_W-1:0] addr);
    return f.valid && (f.dest == addr);
  endfunction

endpackage

// File: rtl/ni_fifo.sv
// Single-clock FIFO with a combinational head; pushes when full and pops when empty are ignored.
module ni_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(1'b0));
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= AW'(1'b0);
      rd_ptr_r <= AW'(1'b0);
      count_r  <= (AW+1)'(1'b0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/switch_local_ni.sv
// Local network interface: per-port TX queues feeding the switch's local inputs, and a
// dual-write RX queue capturing flits ejected on either switch output.
module switch_local_ni
  import ring_flit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR      = 4'b0010,
  parameter int                TX_DEPTH  = 4,
  parameter int                RX_DEPTH  = 4,
  parameter int                STALL_MAX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              tx_port,
  input  logic [ADDR_W-1:0] tx_dest,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_err,
  output logic [FLIT_W-1:0] port0_local_o,
  output logic [FLIT_W-1:0] port1_local_o,
  input  logic              portl0_ack,
  input  logic              portl1_ack,
  input  logic [FLIT_W-1:0] port0_ej_i,
  input  logic [FLIT_W-1:0] port1_ej_i,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_port,
  output logic [DATA_W-1:0] rx_data,
  output logic [7:0]        rx_drop_cnt,
  output logic [1:0]        tx_stall
);

  localparam int SW   = $clog2(STALL_MAX + 1);
  localparam int RAW  = $clog2(RX_DEPTH);
  localparam int RX_W = 1 + DATA_W;

  flit_t             tx_flit_s;
  logic              tx_self_s;
  logic              tx_accept_s;
  logic [1:0]        push_s;
  logic [1:0]        pop_s;
  logic [1:0]        ack_s;
  logic [1:0]        full_s;
  logic [1:0]        empty_s;
  logic [FLIT_W-1:0] head0_s;
  logic [FLIT_W-1:0] head1_s;
  logic              tx_err_r;
  logic [SW-1:0]     stall_cnt_r [2];

  assign tx_flit_s   = '{data: tx_data, valid: 1'b1, dest: tx_dest};
  assign tx_self_s   = (tx_dest == ADDR);
  assign tx_accept_s = tx_valid & tx_ready;
  assign push_s[0]   = tx_accept_s & ~tx_self_s & ~tx_port;
  assign push_s[1]   = tx_accept_s & ~tx_self_s & tx_port;
  assign ack_s       = {portl1_ack, portl0_ack};
  assign pop_s       = ack_s & ~empty_s;
  assign tx_err      = tx_err_r;

  ni_fifo #(.W(FLIT_W), .DEPTH(TX_DEPTH)) u_txq0 (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s[0]),
    .wdata (tx_flit_s),
    .pop   (pop_s[0]),
    .head  (head0_s),
    .full  (full_s[0]),
    .empty (empty_s[0])
  );

  ni_fifo #(.W(FLIT_W), .DEPTH(TX_DEPTH)) u_txq1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s[1]),
    .wdata (tx_flit_s),
    .pop   (pop_s[1]),
    .head  (head1_s),
    .full  (full_s[1]),
    .empty (empty_s[1])
  );

  // Ready and local outputs come from queue state only, never from the acks.
  always_comb begin
    if (tx_port) tx_ready = ~full_s[1];
    else         tx_ready = ~full_s[0];
    if (empty_s[0]) port0_local_o = 8'h00;
    else            port0_local_o = head0_s;
    if (empty_s[1]) port1_local_o = 8'h00;
    else            port1_local_o = head1_s;
  end

  // Self-addressed flits are swallowed so they cannot alias an ejection.
  always_ff @(posedge clk) begin
    if (rst) tx_err_r <= 1'b0;
    else     tx_err_r <= tx_accept_s & tx_self_s;
  end

  // Consecutive unacked cycles on a present head, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r[0] <= SW'(1'b0);
      stall_cnt_r[1] <= SW'(1'b0);
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (empty_s[i] || ack_s[i])                 stall_cnt_r[i] <= SW'(1'b0);
        else if (stall_cnt_r[i] != SW'(STALL_MAX)) stall_cnt_r[i] <= stall_cnt_r[i] + SW'(1'b1);
        else                                        stall_cnt_r[i] <= stall_cnt_r[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) tx_stall[i] = (stall_cnt_r[i] == SW'(STALL_MAX));
  end

  logic [RX_W-1:0] rx_mem_r [RX_DEPTH];
  logic [RAW-1:0]  rx_wr_r;
  logic [RAW-1:0]  rx_rd_r;
  logic [RAW:0]    rx_cnt_r;
  logic [7:0]      drop_cnt_r;
  logic [1:0]      ej_s;
  logic            rx_pop_s;
  logic [RAW+1:0]  rx_free_s;
  logic            wr0_en_s;
  logic            wr1_en_s;
  logic [RX_W-1:0] wr0_data_s;
  logic [RX_W-1:0] wr1_data_s;
  logic [1:0]      n_wr_s;
  logic [1:0]      n_drop_s;
  logic [8:0]      drop_sum_s;

  assign ej_s[0]     = is_eject(port0_ej_i, ADDR);
  assign ej_s[1]     = is_eject(port1_ej_i, ADDR);
  assign rx_valid    = (rx_cnt_r != (RAW+1)'(1'b0));
  assign rx_pop_s    = rx_valid & rx_ready;
  // A same-cycle pop frees its slot for this cycle's writes.
  assign rx_free_s   = (RAW+2)'(RX_DEPTH) - (RAW+2)'(rx_cnt_r) + (RAW+2)'(rx_pop_s);
  assign n_wr_s      = {1'b0, wr0_en_s} + {1'b0, wr1_en_s};
  assign drop_sum_s  = {1'b0, drop_cnt_r} + {7'b0000000, n_drop_s};
  assign rx_drop_cnt = drop_cnt_r;

  // Port 0 takes the first free slot; port 1 gets a slot only if one remains.
  always_comb begin
    wr0_en_s   = 1'b0;
    wr1_en_s   = 1'b0;
    wr0_data_s = {1'b0, port0_ej_i[FLIT_W-1 -: DATA_W]};
    wr1_data_s = {1'b1, port1_ej_i[FLIT_W-1 -: DATA_W]};
    n_drop_s   = 2'd0;
    case (ej_s)
      2'b01: begin
        if (rx_free_s != (RAW+2)'(1'b0)) wr0_en_s = 1'b1;
        else                              n_drop_s = 2'd1;
      end
      2'b10: begin
        wr0_data_s = wr1_data_s;
        if (rx_free_s != (RAW+2)'(1'b0)) wr0_en_s = 1'b1;
        else                              n_drop_s = 2'd1;
      end
      2'b11: begin
        if (rx_free_s >= (RAW+2)'(2'd2)) begin
          wr0_en_s = 1'b1;
          wr1_en_s = 1'b1;
        end else if (rx_free_s == (RAW+2)'(1'b1)) begin
          wr0_en_s = 1'b1;
          n_drop_s = 2'd1;
        end else begin
          n_drop_s = 2'd2;
        end
      end
      default: begin
        wr0_en_s = 1'b0;
      end
    endcase
  end

  // RX queue state, storage and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_r    <= RAW'(1'b0);
      rx_rd_r    <= RAW'(1'b0);
      rx_cnt_r   <= (RAW+1)'(1'b0);
      drop_cnt_r <= 8'h00;
    end else begin
      if (wr0_en_s) rx_mem_r[rx_wr_r] <= wr0_data_s;
      if (wr1_en_s) rx_mem_r[rx_wr_r + RAW'(1'b1)] <= wr1_data_s;
      rx_wr_r    <= rx_wr_r + RAW'(n_wr_s);
      rx_rd_r    <= rx_rd_r + RAW'(rx_pop_s);
      rx_cnt_r   <= rx_cnt_r + (RAW+1)'(n_wr_s) - (RAW+1)'(rx_pop_s);
      drop_cnt_r <= drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
    end
  end

  always_comb begin
    if (rx_valid) begin
      rx_port = rx_mem_r[rx_rd_r][RX_W-1];
      rx_data = rx_mem_r[rx_rd_r][DATA_W-1:0];
    end else begin
      rx_port = 1'b0;
      rx_data = 3'b000;
    end
  end

endmodule
